// File: rtl/string_hw_sequencer.sv
// Walks a string operand word by word through an external per-word engine and
// reports the first non-zero word result. Optional watchdog: STRING_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start; done/result/mismatch_word hold the last outcome
// ISSUE | one-cycle eng_go for word idx
// WAIT  | waiting for eng_done from the engine
// EVAL  | inspect captured word result: finish or advance to next word
module string_hw_sequencer #(
  parameter int MAX_WORDS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  length,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  mismatch_word,
  output logic        err,
  output logic        eng_go,
  output logic [3:0]  eng_index,
  output logic [7:0]  eng_length,
  input  logic        eng_done,
  input  logic [31:0] eng_result
);

  if (MAX_WORDS < 1 || MAX_WORDS > 15) begin : g_bad_max_words
    $error("MAX_WORDS must be in 1..15 (4-bit word index, 4'hF reserved)");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
    $error("TIMEOUT_CYCLES must be in 1..255 (8-bit watchdog)");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    EVAL  = 2'd3
  } state_t;

  localparam logic [8:0] MaxWords9 = 9'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  last_q, last_d;
  logic [7:0]  len_q, len_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  mw_q, mw_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [8:0]  words_ceil;
  logic [8:0]  nwords;
  logic        tmo_hit;

  // Nine bits so length=255 plus rounding does not wrap.
  always_comb begin
    words_ceil = ({1'b0, length} + 9'd3) >> 2;
    nwords     = (words_ceil > MaxWords9) ? MaxWords9 : words_ceil;
  end

`ifdef STRING_SEQ_TIMEOUT_EN
  localparam logic [7:0] TmoLimit = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_q;

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_ff @(posedge clk) begin
    if (reset || state_q != WAIT) begin
      tmo_q <= '0;
    end else if (!eng_done) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end

  assign tmo_hit = (state_q == WAIT) && !eng_done && ((tmo_q + 8'd1) == TmoLimit);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      len_q    <= '0;
      cap_q    <= '0;
      result_q <= '0;
      mw_q     <= 4'hF;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      len_q    <= len_d;
      cap_q    <= cap_d;
      result_q <= result_d;
      mw_q     <= mw_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    len_d    = len_q;
    cap_d    = cap_q;
    result_d = result_q;
    mw_d     = mw_q;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d  = length;
          done_d = 1'b0;
          err_d  = 1'b0;
          idx_d  = '0;
          if (nwords == 9'd0) begin
            // Empty string completes immediately without touching the engine.
            done_d   = 1'b1;
            result_d = '0;
            mw_d     = 4'hF;
          end else begin
            last_d  = 4'(nwords - 9'd1);
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (eng_done) begin
          cap_d   = eng_result;
          state_d = EVAL;
        end else if (tmo_hit) begin
          err_d    = 1'b1;
          done_d   = 1'b1;
          result_d = 32'hFFFF_FFFF;
          mw_d     = idx_q;
          state_d  = IDLE;
        end
      end

      EVAL: begin
        if (cap_q != 32'd0) begin
          result_d = cap_q;
          mw_d     = idx_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (idx_q == last_q) begin
          result_d = '0;
          mw_d     = 4'hF;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ISSUE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign eng_go        = (state_q == ISSUE);
  assign eng_index     = idx_q;
  assign eng_length    = len_q;
  assign done          = done_q;
  assign result        = result_q;
  assign mismatch_word = mw_q;
  assign err           = err_q;

endmodule

// File: tb/tb_string_hw_sequencer.sv
// Directed, table-driven bench for string_hw_sequencer with a one-cycle-latency
// engine model; extra hand sequences for busy-start, mid-run reset and watchdog.
module tb_string_hw_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  mismatch_word;
  logic        err;
  logic        eng_go;
  logic [3:0]  eng_index;
  logic [7:0]  eng_length;
  logic        eng_done;
  logic [31:0] eng_result;

  string_hw_sequencer #(
    .MAX_WORDS      (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .mismatch_word (mismatch_word),
    .err           (err),
    .eng_go        (eng_go),
    .eng_index     (eng_index),
    .eng_length    (eng_length),
    .eng_done      (eng_done),
    .eng_result    (eng_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Engine model configuration, written by the main sequence.
  logic [3:0]  bad_word    = 4'hF;
  logic [31:0] bad_val     = 32'h0;
  logic [3:0]  no_resp_idx = 4'hF;
  logic        stale_req   = 1'b0;

  // Monitor counters, written only by the monitor.
  int         go_total = 0;
  int         idx_err  = 0;
  int         stab_err = 0;
  int         len_err  = 0;
  int         dbl_go   = 0;
  logic [7:0] exp_len  = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine: answers eng_done one cycle after eng_go with a table-selected word.
  initial begin
    logic       hit;
    logic [3:0] ridx;
    eng_done   = 1'b0;
    eng_result = 32'h0;
    forever begin
      @(negedge clk);
      hit  = (eng_go === 1'b1) && (eng_index != no_resp_idx);
      ridx = eng_index;
      @(posedge clk);
      #1;
      eng_done   = hit || stale_req;
      eng_result = (hit && ridx == bad_word) ? bad_val : 32'h0;
    end
  end

  // Protocol monitor: index order, index/length stability, single-cycle go.
  initial begin
    int   nxt_idx;
    logic last_idx_v;
    logic [3:0] last_go_idx;
    logic go_prev;
    nxt_idx     = 0;
    last_go_idx = 4'd0;
    go_prev     = 1'b0;
    last_idx_v  = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b0) nxt_idx = 0;
      if (eng_go === 1'b1) begin
        go_total++;
        if (int'(eng_index) != nxt_idx) idx_err++;
        nxt_idx     = int'(eng_index) + 1;
        last_go_idx = eng_index;
        last_idx_v  = 1'b1;
        if (go_prev) dbl_go++;
      end else if (busy === 1'b1 && last_idx_v && eng_index != last_go_idx) begin
        stab_err++;
      end
      if (busy === 1'b1 && eng_length != exp_len) len_err++;
      go_prev = (eng_go === 1'b1);
    end
  end

  // One start/length request; returns eng_go count and the cycle done rose.
  task automatic run_op(input logic [7:0] len, input bit poke,
                        output int ngo, output int dcyc);
    int g0;
    int cyc;
    exp_len = len;
    g0      = go_total;
    dcyc    = -1;
    @(posedge clk); #1;
    start  = 1'b1;
    length = len;
    @(posedge clk); #1;
    start  = 1'b0;
    length = 8'h5A;
    cyc    = 1;
    while (cyc < 400) begin
      @(negedge clk);
      if (cyc == 1) begin
        if (len == 8'd0) chk("busy_len0", 32'(busy), 32'd0);
        else begin
          chk("done_cleared", 32'(done), 32'd0);
          chk("busy_started", 32'(busy), 32'd1);
        end
      end
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 5) begin
        start  = 1'b1;
        length = 8'd4;
      end else if (poke && cyc == 6) begin
        start  = 1'b0;
        length = 8'h5A;
      end
    end
    start = 1'b0;
    if (dcyc < 0) chk("done_within_bound", 32'd0, 32'd1);
    ngo = go_total - g0;
  endtask

  typedef struct {
    logic [7:0]  len;
    logic [3:0]  bad_word;
    logic [31:0] bad_val;
    bit          poke;
    int          exp_ngo;
    int          exp_cyc;
    logic [31:0] exp_result;
    logic [3:0]  exp_mw;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ngo;
    int dcyc;
    int i0, s0, l0, d0;
    int found;

    vecs[0] = '{8'd12,  4'hF, 32'h0,         1'b0, 3, 10, 32'h0,         4'hF};
    vecs[1] = '{8'd32,  4'd2, 32'h0000_0041, 1'b0, 3, 10, 32'h0000_0041, 4'd2};
    vecs[2] = '{8'd0,   4'hF, 32'h0,         1'b0, 0, 1,  32'h0,         4'hF};
    vecs[3] = '{8'd200, 4'hF, 32'h0,         1'b1, 8, 25, 32'h0,         4'hF};
    vecs[4] = '{8'd1,   4'hF, 32'h0,         1'b0, 1, 4,  32'h0,         4'hF};
    vecs[5] = '{8'd5,   4'd0, 32'hDEAD_BEEF, 1'b0, 1, 4,  32'hDEAD_BEEF, 4'd0};
    vecs[6] = '{8'd4,   4'd1, 32'h0000_1234, 1'b0, 1, 4,  32'h0,         4'hF};
    vecs[7] = '{8'd33,  4'd7, 32'h8000_0000, 1'b0, 8, 25, 32'h8000_0000, 4'd7};

    reset  = 1'b1;
    start  = 1'b0;
    length = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    chk("rst_go",     32'(eng_go), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_mw",     32'(mismatch_word), 32'hF);
    chk("rst_index",  32'(eng_index), 32'd0);
    chk("rst_length", 32'(eng_length), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      bad_word = vecs[v].bad_word;
      bad_val  = vecs[v].bad_val;
      i0 = idx_err; s0 = stab_err; l0 = len_err; d0 = dbl_go;
      run_op(vecs[v].len, vecs[v].poke, ngo, dcyc);
      chk($sformatf("v%0d_ngo", v),     32'(ngo), 32'(vecs[v].exp_ngo));
      chk($sformatf("v%0d_cycle", v),   32'(dcyc), 32'(vecs[v].exp_cyc));
      chk($sformatf("v%0d_result", v),  result, vecs[v].exp_result);
      chk($sformatf("v%0d_mw", v),      32'(mismatch_word), 32'(vecs[v].exp_mw));
      chk($sformatf("v%0d_err", v),     32'(err), 32'd0);
      chk($sformatf("v%0d_idle", v),    32'(busy), 32'd0);
      chk($sformatf("v%0d_idx_seq", v), 32'(idx_err - i0), 32'd0);
      chk($sformatf("v%0d_stable", v),  32'(stab_err - s0), 32'd0);
      chk($sformatf("v%0d_len", v),     32'(len_err - l0), 32'd0);
      chk($sformatf("v%0d_one_go", v),  32'(dbl_go - d0), 32'd0);
    end

    // done and result hold while idle.
    repeat (5) @(negedge clk);
    chk("sticky_done",   32'(done), 32'd1);
    chk("sticky_result", result, 32'h8000_0000);
    chk("sticky_mw",     32'(mismatch_word), 32'd7);

    // Reset during WAIT of word 1, then a stale eng_done.
    bad_word    = 4'hF;
    no_resp_idx = 4'd1;
    exp_len     = 8'd16;
    ngo         = go_total;
    @(posedge clk); #1;
    start  = 1'b1;
    length = 8'd16;
    @(posedge clk); #1;
    start  = 1'b0;
    found  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (eng_go === 1'b1 && eng_index == 4'd1) begin
        found = 1;
        break;
      end
    end
    chk("go1_seen", 32'(found), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("in_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",   32'(busy), 32'd0);
    chk("mid_rst_done",   32'(done), 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_mw",     32'(mismatch_word), 32'hF);
    chk("mid_rst_index",  32'(eng_index), 32'd0);
    chk("mid_rst_length", 32'(eng_length), 32'd0);
    reset       = 1'b0;
    no_resp_idx = 4'hF;
    stale_req   = 1'b1;
    @(negedge clk);
    stale_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale_busy",   32'(busy), 32'd0);
    chk("stale_done",   32'(done), 32'd0);
    chk("stale_result", result, 32'h0);
    chk("stale_ngo",    32'(go_total - ngo), 32'd2);

    run_op(8'd4, 1'b0, ngo, dcyc);
    chk("post_rst_ngo",    32'(ngo), 32'd1);
    chk("post_rst_cycle",  32'(dcyc), 32'd4);
    chk("post_rst_result", result, 32'h0);
    chk("post_rst_mw",     32'(mismatch_word), 32'hF);

`ifdef STRING_SEQ_TIMEOUT_EN
    // Engine silent on word 0: 16 WAIT cycles (cycles 2..17), done seen at 18.
    no_resp_idx = 4'd0;
    run_op(8'd4, 1'b0, ngo, dcyc);
    no_resp_idx = 4'hF;
    chk("tmo_ngo",    32'(ngo), 32'd1);
    chk("tmo_cycle",  32'(dcyc), 32'd18);
    chk("tmo_err",    32'(err), 32'd1);
    chk("tmo_result", result, 32'hFFFF_FFFF);
    chk("tmo_mw",     32'(mismatch_word), 32'd0);
    run_op(8'd8, 1'b0, ngo, dcyc);
    chk("tmo_clear_err", 32'(err), 32'd0);
    chk("tmo_clear_ngo", 32'(ngo), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
